fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined 16-bit core, directly upstream of the fetch/decode pipeline register. It owns the PC, issues requests to a variable-latency instruction memory, and handles hazard stalls, taken-branch redirects from decode, and HLT. It presents one instruction per cycle, or a no-op bubble, to the fetch/decode register, together with its PC and write enable.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'hE000, bubble instruction (PCS R0)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall from decode: hold PC, do not write F/D
- branch_taken  in  1  taken branch/jump resolved in decode
- branch_target  in  16  redirect address, valid with branch_taken
- imem_req  out  1  instruction memory request
- imem_addr  out  16  request address; stable while imem_req is high and imem_valid is low
- imem_data  in  16  returned instruction
- imem_valid  in  1  data valid; may rise in the same cycle as the request
- curr_pc  out  16  PC+2 of the delivered instruction (F/D curr_pc)
- curr_instr  out  16  delivered instruction or NOP_INSTR
- fd_enable  out  1  F/D register write enable
- halted  out  1  HLT fetched; fetch stopped

## Operation
- State machine with three states:
  - FETCH: normal fetching.
  - DISCARD: an outstanding request must be drained and its data dropped.
  - HALTED: fetch has stopped after HLT.
- One-entry skid buffer (buf_valid, buf_instr, buf_pc) holds an instruction that returns while stall=1.
- **Instruction source.** The source is the buffer when buf_valid, else imem_data when imem_valid in FETCH. Otherwise there is no instruction and the stage delivers a bubble.
- **imem_req.** Asserted when state is FETCH or DISCARD and buf_valid=0. The request address is imem_addr = PC.
- **Priority:** rst > branch_taken > stall > normal.
- **branch_taken (any state):**
  - Drive fd_enable=1 and curr_instr=NOP_INSTR.
  - Clear buf_valid.
  - If a request is outstanding (imem_req=1, imem_valid=0), latch the target into redirect_pc and go to DISCARD. Otherwise load PC with branch_target and go to FETCH.
  - Exits HALTED and clears halted.
- **stall=1, no branch:**
  - fd_enable=0 and the PC holds.
  - If imem_valid arrives in FETCH, capture the instruction into the buffer and advance PC by 2 (unless it is HLT).
- **Normal delivery (stall=0):**
  - fd_enable=1; curr_instr is the source instruction or NOP_INSTR.
  - When the source is memory, PC <= PC+2. When the source is the buffer, clear buf_valid and do not advance PC again.
- **HLT** (instr[15:12]==4'hF) on delivery or capture:
  - The HLT is delivered once.
  - The PC holds at the HLT address and the state goes to HALTED.
  - In HALTED: imem_req=0, fd_enable=1, curr_instr=NOP_INSTR, halted=1.
- **DISCARD:**
  - Hold imem_addr and keep imem_req high.
  - When imem_valid arrives, drop the data, load PC with redirect_pc and go to FETCH.
  - Output a bubble every non-stall cycle.
  - A second branch_taken in DISCARD overwrites redirect_pc.
- **Arithmetic:** PC+2 is 16-bit, modulo 2^16; 16'hFFFE wraps to 16'h0000.

## Timing
- **Reset values:** PC=RESET_PC, state FETCH, buf_valid=0. All outputs are 0 except curr_instr=NOP_INSTR and imem_addr=RESET_PC.
- **Hit latency:** with imem_valid combinational, an instruction reaches F/D at the same edge it is fetched, giving one instruction per cycle.
- **Branch redirect:** the target address is requested in the cycle after branch_taken, or after drain completes in DISCARD.
- **Stall release:** a buffered instruction is delivered in the first cycle with stall=0, with no memory access that cycle.
- **Reset mid-miss:** rst asserted during an outstanding request abandons it. The memory must tolerate the request being deasserted.

## Structure
- Shared package contents:
  - NOP_INSTR
  - OPC_HLT (4'hF)
  - state encoding (FETCH=2'd0, DISCARD=2'd1, HALTED=2'd2)
- One natural sub-module: fetch_skid_buf, the one-entry buffer with load/clear and stored instr/pc.
- PC and redirect_pc are reused from the codebase's 16-bit Register.

## Test plan
- Reset, then zero-latency memory returning 16'h1234, 16'h5678 -> F/D receives them with curr_pc 16'h0002 and 16'h0004; fd_enable=1 each cycle.
- Memory latency 3 cycles at PC 16'h0010 -> imem_addr=16'h0010 held for 3 cycles, two NOP bubbles, then the instruction with curr_pc=16'h0012.
- stall=1 for 2 cycles while imem_valid returns 16'hA0B1 -> fd_enable=0 and PC advances once; on release, 16'hA0B1 is delivered with no imem_req that cycle.
- branch_taken to 16'h0100 while a miss is outstanding at 16'h0040 -> DISCARD; the late 16'h0040 data is dropped; next imem_addr=16'h0100; fd_flush bubble observed.
- HLT 16'hF000 at 16'h0020 -> delivered once, halted=1, imem_req=0, PC=16'h0020; then branch_taken to 16'h0030 -> halted=0 and fetch resumes at 16'h0030.
- PC=16'hFFFE with a hit -> next imem_addr=16'h0000; rst asserted mid-miss -> all outputs at reset values the following cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'hE000;
  localparam logic [3:0]  OPC_HLT   = 4'hF;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDiscard = 2'd1,
    StHalted  = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(logic [15:0] instr);
    return instr[15:12] == OPC_HLT;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction (and its PC) that returned during a stall.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc
);

  logic        valid_q;
  logic [15:0] instr_q, pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and feeds the F/D
// register one instruction (or a bubble) per cycle, handling stalls, redirects and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] curr_pc,
  output logic [15:0] curr_instr,
  output logic        fd_enable,
  output logic        halted
);

  import fetch_stage_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d, redirect_q, redirect_d;
  logic         buf_valid, buf_load, buf_clear;
  logic [15:0]  buf_instr, buf_pc;
  logic         req, outstanding, mem_hit;
  logic [15:0]  pc_plus2;

  assign pc_plus2    = pc_q + 16'd2;
  assign req         = (state_q != StHalted) && !buf_valid;
  assign outstanding = req && !imem_valid;
  // Memory is a legal source only in normal fetch with the buffer empty.
  assign mem_hit     = (state_q == StFetch) && !buf_valid && imem_valid;

  fetch_skid_buf u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (imem_data),
    .pc_in    (pc_q),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    imem_req   = req;
    imem_addr  = pc_q;
    fd_enable  = 1'b0;
    curr_instr = NOP_INSTR;
    curr_pc    = 16'h0000;
    halted     = (state_q == StHalted);

    if (rst) begin
      imem_req  = 1'b0;
      imem_addr = RESET_PC;
      halted    = 1'b0;
    end else if (branch_taken) begin
      fd_enable = 1'b1;
      buf_clear = 1'b1;
      if (outstanding) begin
        redirect_d = branch_target;
        state_d    = StDiscard;
      end else begin
        pc_d    = branch_target;
        state_d = StFetch;
      end
    end else if (stall) begin
      if (mem_hit) begin
        buf_load = 1'b1;
        if (is_hlt(imem_data)) state_d = StHalted;
        else                   pc_d    = pc_plus2;
      end else if (state_q == StDiscard && imem_valid) begin
        pc_d    = redirect_q;
        state_d = StFetch;
      end
    end else begin
      fd_enable = 1'b1;
      if (buf_valid) begin
        // PC already advanced when the buffer was loaded.
        curr_instr = buf_instr;
        curr_pc    = buf_pc + 16'd2;
        buf_clear  = 1'b1;
      end else if (mem_hit) begin
        curr_instr = imem_data;
        curr_pc    = pc_plus2;
        if (is_hlt(imem_data)) state_d = StHalted;
        else                   pc_d    = pc_plus2;
      end else if (state_q == StDiscard && imem_valid) begin
        pc_d    = redirect_q;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      redirect_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural reference checked every cycle, plus literal pins.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'hE000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_valid = 1'b0;
  logic [15:0] branch_target = '0, imem_data = '0;
  logic        imem_req, fd_enable, halted;
  logic [15:0] imem_addr, curr_pc, curr_instr;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .curr_pc       (curr_pc),
    .curr_instr    (curr_instr),
    .fd_enable     (fd_enable),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 = fetching, 1 = draining a dead request, 2 = halted.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        m_buf[$], n_buf[$];
  int          m_mode = 0, n_mode = 0;
  logic [15:0] m_pc = RST_PC, n_pc = RST_PC, m_redir = '0, n_redir = '0;
  logic        e_req, e_en, e_halt;
  logic [15:0] e_addr, e_instr, e_cpc;

  task automatic model_eval();
    ent_t e;
    n_pc = m_pc; n_mode = m_mode; n_redir = m_redir; n_buf = m_buf;
    e_req = 1'b0; e_addr = m_pc; e_en = 1'b0; e_instr = NOP; e_cpc = 16'h0000;
    e_halt = (m_mode == 2);
    if (rst) begin
      e_addr = RST_PC; e_halt = 1'b0;
      n_pc = RST_PC; n_mode = 0; n_buf.delete();
      return;
    end
    e_req = (m_mode != 2) && (m_buf.size() == 0);
    if (branch_taken) begin
      e_en = 1'b1;
      n_buf.delete();
      if (e_req && !imem_valid) begin n_redir = branch_target; n_mode = 1; end
      else begin n_pc = branch_target; n_mode = 0; end
    end else if (m_mode == 1) begin
      e_en = !stall;
      if (imem_valid) begin n_pc = m_redir; n_mode = 0; end
    end else if (m_buf.size() != 0) begin
      if (!stall) begin
        e_en = 1'b1; e_instr = m_buf[0].instr; e_cpc = m_buf[0].pc + 16'd2;
        n_buf.delete();
      end
    end else if (m_mode == 0 && imem_valid) begin
      if (stall) begin
        e.instr = imem_data; e.pc = m_pc;
        n_buf.push_back(e);
      end else begin
        e_en = 1'b1; e_instr = imem_data; e_cpc = m_pc + 16'd2;
      end
      if (imem_data[15:12] == 4'hF) n_mode = 2;
      else                          n_pc = m_pc + 16'd2;
    end else begin
      e_en = !stall;
    end
  endtask

  always @(negedge clk) begin
    model_eval();
    chk("imem_req", {15'd0, imem_req}, {15'd0, e_req});
    chk("imem_addr", imem_addr, e_addr);
    chk("fd_enable", {15'd0, fd_enable}, {15'd0, e_en});
    chk("curr_instr", curr_instr, e_instr);
    chk("curr_pc", curr_pc, e_cpc);
    chk("halted", {15'd0, halted}, {15'd0, e_halt});
  end

  always @(posedge clk) begin
    m_pc = n_pc; m_mode = n_mode; m_redir = n_redir; m_buf = n_buf;
  end

  // Apply one cycle of inputs, then park just after the following negedge for literal checks.
  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] t,
                       input logic v, input logic [15:0] d);
    @(posedge clk); #1;
    rst = r; stall = s; branch_taken = b; branch_target = t; imem_valid = v; imem_data = d;
    @(negedge clk); #1;
  endtask

  initial begin
    drive(1, 0, 0, 16'h0, 0, 16'h0);
    drive(1, 0, 0, 16'h0, 0, 16'h0);
    chk("rst_req", {15'd0, imem_req}, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", curr_instr, 16'hE000);
    chk("rst_fd_en", {15'd0, fd_enable}, 16'h0000);

    // Zero-latency hits
    drive(0, 0, 0, 16'h0, 1, 16'h1234);
    chk("hit1_instr", curr_instr, 16'h1234);
    chk("hit1_pc", curr_pc, 16'h0002);
    drive(0, 0, 0, 16'h0, 1, 16'h5678);
    chk("hit2_instr", curr_instr, 16'h5678);
    chk("hit2_pc", curr_pc, 16'h0004);
    chk("hit2_en", {15'd0, fd_enable}, 16'h0001);

    // Three-cycle miss at 0x0010
    drive(0, 0, 1, 16'h0010, 1, 16'h0000);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    chk("miss_addr1", imem_addr, 16'h0010);
    chk("miss_bubble1", curr_instr, 16'hE000);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    chk("miss_addr2", imem_addr, 16'h0010);
    drive(0, 0, 0, 16'h0, 1, 16'h1111);
    chk("miss_addr3", imem_addr, 16'h0010);
    chk("miss_instr", curr_instr, 16'h1111);
    chk("miss_pc", curr_pc, 16'h0012);

    // Stall while data returns, then release from the skid buffer
    drive(0, 1, 0, 16'h0, 1, 16'hA0B1);
    chk("stall_en", {15'd0, fd_enable}, 16'h0000);
    drive(0, 1, 0, 16'h0, 0, 16'h0);
    chk("stall_addr", imem_addr, 16'h0014);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    chk("rel_instr", curr_instr, 16'hA0B1);
    chk("rel_pc", curr_pc, 16'h0014);
    chk("rel_req", {15'd0, imem_req}, 16'h0000);

    // Redirect during an outstanding miss at 0x0040
    drive(0, 0, 1, 16'h0040, 1, 16'h0000);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    drive(0, 0, 1, 16'h0100, 0, 16'h0);
    chk("flush_instr", curr_instr, 16'hE000);
    chk("flush_en", {15'd0, fd_enable}, 16'h0001);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    chk("disc_addr", imem_addr, 16'h0040);
    drive(0, 0, 0, 16'h0, 1, 16'h7777);
    chk("disc_drop", curr_instr, 16'hE000);
    drive(0, 0, 0, 16'h0, 1, 16'h2222);
    chk("redir_addr", imem_addr, 16'h0100);
    chk("redir_instr", curr_instr, 16'h2222);

    // HLT at 0x0020, then resume at 0x0030
    drive(0, 0, 1, 16'h0020, 1, 16'h0000);
    drive(0, 0, 0, 16'h0, 1, 16'hF000);
    chk("hlt_instr", curr_instr, 16'hF000);
    chk("hlt_pc", curr_pc, 16'h0022);
    drive(0, 0, 0, 16'h0, 1, 16'h3333);
    chk("hlt_halted", {15'd0, halted}, 16'h0001);
    chk("hlt_req", {15'd0, imem_req}, 16'h0000);
    chk("hlt_addr", imem_addr, 16'h0020);
    chk("hlt_bubble", curr_instr, 16'hE000);
    drive(0, 0, 1, 16'h0030, 0, 16'h0);
    drive(0, 0, 0, 16'h0, 1, 16'h4444);
    chk("resume_halted", {15'd0, halted}, 16'h0000);
    chk("resume_addr", imem_addr, 16'h0030);
    chk("resume_instr", curr_instr, 16'h4444);

    // PC wrap, then reset mid-miss
    drive(0, 0, 1, 16'hFFFE, 1, 16'h0000);
    drive(0, 0, 0, 16'h0, 1, 16'h5555);
    chk("wrap_pc", curr_pc, 16'h0000);
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    chk("wrap_addr", imem_addr, 16'h0000);
    drive(0, 0, 1, 16'h0200, 0, 16'h0);
    drive(1, 0, 0, 16'h0, 0, 16'h0);
    drive(1, 0, 0, 16'h0, 0, 16'h0);
    chk("mrst_req", {15'd0, imem_req}, 16'h0000);
    chk("mrst_addr", imem_addr, 16'h0000);
    chk("mrst_en", {15'd0, fd_enable}, 16'h0000);
    drive(0, 0, 0, 16'h0, 1, 16'h6666);
    chk("post_rst_addr", imem_addr, 16'h0000);
    chk("post_rst_instr", curr_instr, 16'h6666);
    chk("post_rst_pc", curr_pc, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
